// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] func;
        logic [3:0] a;
    } cmd_t;

    localparam logic [2:0] FN_CONCAT = 3'd0;
    localparam logic [2:0] FN_RCADD  = 3'd1;
    localparam logic [2:0] FN_ADD    = 3'd2;
    localparam logic [2:0] FN_ORXOR  = 3'd3;
    localparam logic [2:0] FN_REDOR  = 3'd4;
    localparam logic [2:0] FN_SHL    = 3'd5;
    localparam logic [2:0] FN_SHR    = 3'd6;
    localparam logic [2:0] FN_MUL    = 3'd7;

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store: DEPTH x 7-bit register file, synchronous write,
// asynchronous read, storage is not reset.
module alu_seq_prog_mem
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  cmd_t          wdata,
    input  logic [AW-1:0] raddr,
    output cmd_t          rdata
);

    cmd_t mem [DEPTH];

    // Store one command entry per accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: holds a short program of {func, a} entries and
// issues them in order over a valid/ready handshake with optional pacing.
// Optional feature macro: ALU_SEQ_LOOP_EN (wrap to entry 0 after the last
// entry instead of stopping in DONE).
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int PACE  = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [2:0]    wr_func,
    input  logic [3:0]    wr_a,
    input  logic          clear,
    input  logic          start,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_func,
    output logic [3:0]    out_a,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   prog_len,
    output logic          prog_full,
    output logic [7:0]    issue_count,
    output logic          wr_err
);

    localparam logic [7:0]    PACE_L  = 8'(PACE);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state, state_n;
    logic [AW-1:0] rd_ptr, rd_ptr_n;
    logic [7:0]    gap_cnt, gap_n;
    logic [AW:0]   len_n;
    logic [7:0]    cnt_n;
    logic          done_n, wr_err_n, out_valid_n, busy_n, prog_full_n;
    logic [2:0]    func_n;
    logic [3:0]    a_n;
    logic          mem_we, hs, last;
    cmd_t          wr_cmd, rd_cmd;

    assign wr_cmd = {wr_func, wr_a};
    assign hs     = out_valid && out_ready;
    assign last   = ({1'b0, rd_ptr} == (prog_len - ONE_L));

    // Read address follows the next pointer so the registered outputs
    // already carry the entry that will be current in the next cycle.
    alu_seq_prog_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(prog_len[AW-1:0]),
        .wdata(wr_cmd),
        .raddr(rd_ptr_n),
        .rdata(rd_cmd)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            gap_cnt     <= '0;
            prog_len    <= '0;
            prog_full   <= 1'b0;
            issue_count <= '0;
            done        <= 1'b0;
            wr_err      <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            out_func    <= '0;
            out_a       <= '0;
        end else begin
            state       <= state_n;
            rd_ptr      <= rd_ptr_n;
            gap_cnt     <= gap_n;
            prog_len    <= len_n;
            prog_full   <= prog_full_n;
            issue_count <= cnt_n;
            done        <= done_n;
            wr_err      <= wr_err_n;
            out_valid   <= out_valid_n;
            busy        <= busy_n;
            out_func    <= func_n;
            out_a       <= a_n;
        end
    end

    // Next-state logic and next values of all registered outputs.
    always_comb begin
        state_n  = state;
        rd_ptr_n = rd_ptr;
        gap_n    = gap_cnt;
        len_n    = prog_len;
        cnt_n    = issue_count;
        done_n   = done;
        wr_err_n = 1'b0;
        mem_we   = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                // clear > wr_en > start; lower requests are dropped.
                if (clear) begin
                    len_n   = '0;
                    done_n  = 1'b0;
                    state_n = IDLE;
                end else if (wr_en) begin
                    if (prog_full) begin
                        wr_err_n = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        len_n   = prog_len + ONE_L;
                        done_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else if (start && (prog_len != '0)) begin
                    rd_ptr_n = '0;
                    cnt_n    = '0;
                    done_n   = 1'b0;
                    state_n  = RUN;
                end
            end
            RUN: begin
                if (wr_en) wr_err_n = 1'b1;
                if (hs) cnt_n = sat_inc8(issue_count);
                if (abort) begin
                    state_n = IDLE;
                end else if (hs) begin
                    if (last) begin
`ifdef ALU_SEQ_LOOP_EN
                        rd_ptr_n = '0;
                        gap_n    = PACE_L;
                        state_n  = (PACE_L != '0) ? GAP : RUN;
`else
                        state_n  = DONE;
                        done_n   = 1'b1;
`endif
                    end else begin
                        rd_ptr_n = rd_ptr + PTR_ONE;
                        gap_n    = PACE_L;
                        state_n  = (PACE_L != '0) ? GAP : RUN;
                    end
                end
            end
            GAP: begin
                if (wr_en) wr_err_n = 1'b1;
                if (abort) begin
                    state_n = IDLE;
                end else if (gap_cnt <= 8'd1) begin
                    state_n = RUN;
                end else begin
                    gap_n = gap_cnt - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        out_valid_n = (state_n == RUN);
        busy_n      = (state_n == RUN) || (state_n == GAP);
        prog_full_n = (len_n == DEPTH_L);
        func_n      = out_valid_n ? rd_cmd.func : out_func;
        a_n         = out_valid_n ? rd_cmd.a    : out_a;
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: two instances (PACE=0 and
// PACE=2) share stimulus and are compared every cycle against a
// behavioural program/step model, plus literal expectations.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic reset_n, wr_en, clear, start, abort, out_ready;
    logic [2:0] wr_func;
    logic [3:0] wr_a;

    logic v0, b0, d0, pf0, we0, v2, b2, d2, pf2, we2;
    logic [2:0] f0, f2;
    logic [3:0] a0, a2;
    logic [AW:0] pl0, pl2;
    logic [7:0] ic0, ic2;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW), .PACE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_func(wr_func), .wr_a(wr_a),
        .clear(clear), .start(start), .abort(abort), .out_valid(v0), .out_ready(out_ready),
        .out_func(f0), .out_a(a0), .busy(b0), .done(d0), .prog_len(pl0),
        .prog_full(pf0), .issue_count(ic0), .wr_err(we0));

    alu_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW), .PACE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_func(wr_func), .wr_a(wr_a),
        .clear(clear), .start(start), .abort(abort), .out_valid(v2), .out_ready(out_ready),
        .out_func(f2), .out_a(a2), .busy(b2), .done(d2), .prog_len(pl2),
        .prog_full(pf2), .issue_count(ic2), .wr_err(we2));

    int errors = 0;
    int checks = 0;

    // Behavioural model per instance: program list, current index,
    // remaining idle cycles, running/done flags, handshake count.
    int m_prog [2][DEPTH];
    int m_len [2];
    int m_idx [2];
    int m_gap [2];
    int m_cnt [2];
    bit m_run [2];
    bit m_done [2];
    bit m_werr [2];
    int pace_of [2] = '{0, 2};

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic model_step(int k);
        bit hs;
        if (!reset_n) begin
            m_len[k] = 0; m_idx[k] = 0; m_gap[k] = 0; m_cnt[k] = 0;
            m_run[k] = 0; m_done[k] = 0; m_werr[k] = 0;
        end else begin
            hs = m_run[k] && (m_gap[k] == 0) && out_ready;
            m_werr[k] = 0;
            if (!m_run[k]) begin
                if (clear) begin
                    m_len[k] = 0; m_done[k] = 0;
                end else if (wr_en) begin
                    if (m_len[k] == DEPTH) m_werr[k] = 1;
                    else begin
                        m_prog[k][m_len[k]] = int'({wr_func, wr_a});
                        m_len[k]++;
                        m_done[k] = 0;
                    end
                end else if (start && m_len[k] > 0) begin
                    m_idx[k] = 0; m_cnt[k] = 0; m_done[k] = 0; m_run[k] = 1; m_gap[k] = 0;
                end
            end else begin
                if (wr_en) m_werr[k] = 1;
                if (hs && m_cnt[k] < 255) m_cnt[k]++;
                if (abort) begin
                    m_run[k] = 0; m_gap[k] = 0;
                end else if (hs) begin
                    if (m_idx[k] == m_len[k] - 1) begin
`ifdef ALU_SEQ_LOOP_EN
                        m_idx[k] = 0; m_gap[k] = pace_of[k];
`else
                        m_run[k] = 0; m_done[k] = 1;
`endif
                    end else begin
                        m_idx[k]++; m_gap[k] = pace_of[k];
                    end
                end else if (m_gap[k] > 0) begin
                    m_gap[k]--;
                end
            end
        end
    endtask

    task automatic check_inst(int k, logic ov, logic [2:0] of, logic [3:0] oa, logic b,
                              logic d, logic [AW:0] pl, logic pf, logic [7:0] ic, logic we);
        bit ev;
        ev = m_run[k] && (m_gap[k] == 0);
        chk($sformatf("out_valid[%0d]", k), int'(ov), int'(ev));
        chk($sformatf("busy[%0d]", k), int'(b), int'(m_run[k]));
        chk($sformatf("done[%0d]", k), int'(d), int'(m_done[k]));
        chk($sformatf("prog_len[%0d]", k), int'(pl), m_len[k]);
        chk($sformatf("prog_full[%0d]", k), int'(pf), int'(m_len[k] == DEPTH));
        chk($sformatf("issue_count[%0d]", k), int'(ic), m_cnt[k]);
        chk($sformatf("wr_err[%0d]", k), int'(we), int'(m_werr[k]));
        if (ev) begin
            chk($sformatf("out_func[%0d]", k), int'(of), (m_prog[k][m_idx[k]] >> 4) & 7);
            chk($sformatf("out_a[%0d]", k), int'(oa), m_prog[k][m_idx[k]] & 15);
        end
    endtask

    // One clock: advance the model with the current inputs, then compare
    // both instances on the falling edge.
    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        check_inst(0, v0, f0, a0, b0, d0, pl0, pf0, ic0, we0);
        check_inst(1, v2, f2, a2, b2, d2, pl2, pf2, ic2, we2);
    endtask

    task automatic wr(logic [2:0] f, logic [3:0] a);
        wr_en = 1'b1; wr_func = f; wr_a = a;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    initial begin
        logic [2:0] lf [3];
        logic [3:0] la [3];
        int lc [3];
        int n, first2, done2_at, bad;

        reset_n = 1'b0; wr_en = 1'b0; clear = 1'b0; start = 1'b0; abort = 1'b0;
        out_ready = 1'b0; wr_func = '0; wr_a = '0;
        tick();
        tick();
        chk("rst_out_valid", int'(v0), 0);
        chk("rst_out_func", int'(f0), 0);
        chk("rst_out_a", int'(a0), 0);
        chk("rst_busy", int'(b0), 0);
        chk("rst_done", int'(d0), 0);
        chk("rst_prog_len", int'(pl0), 0);
        chk("rst_issue_count", int'(ic0), 0);
        chk("rst_wr_err", int'(we0), 0);
        reset_n = 1'b1;
        tick();

        // Three-entry program, ready held high.
        wr(FN_ADD, 4'd3); wr(FN_MUL, 4'd5); wr(FN_SHL, 4'd1);
        chk("len_after_3_writes", int'(pl0), 3);
`ifndef ALU_SEQ_LOOP_EN
        out_ready = 1'b1;
        pulse_start();
        n = 0; first2 = -1; done2_at = -1;
        for (int i = 0; i < 3; i++) begin lf[i] = '0; la[i] = '0; lc[i] = 0; end
        for (int c = 0; c < 40; c++) begin
            if (v0 && n < 3) begin lf[n] = f0; la[n] = a0; lc[n] = c; n++; end
            if (v2 && first2 < 0) first2 = c;
            if (d2 && done2_at < 0) done2_at = c;
            if (d0 && d2) break;
            tick();
        end
        chk("p0_steps", n, 3);
        chk("p0_e0_func", int'(lf[0]), 2); chk("p0_e0_a", int'(la[0]), 3);
        chk("p0_e1_func", int'(lf[1]), 7); chk("p0_e1_a", int'(la[1]), 5);
        chk("p0_e2_func", int'(lf[2]), 5); chk("p0_e2_a", int'(la[2]), 1);
        chk("p0_back_to_back", lc[2] - lc[0], 2);
        chk("p0_done", int'(d0), 1);
        chk("p0_issue_count", int'(ic0), 3);
        chk("p0_busy", int'(b0), 0);
        chk("p2_first_valid_to_done", done2_at - first2, 7);
        chk("p2_issue_count", int'(ic2), 3);

        // Stall on entry 1 for four cycles.
        pulse_start();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", int'(v0), 1);
            chk("stall_func", int'(f0), 7);
            chk("stall_a", int'(a0), 5);
            tick();
        end
        chk("stall_hold_func", int'(f0), 7);
        out_ready = 1'b1;
        tick();
        chk("after_stall_func", int'(f0), 5);
        chk("after_stall_a", int'(a0), 1);
        for (int c = 0; c < 40 && !(d0 && d2); c++) tick();
        chk("stall_done", int'(d0), 1);
        chk("stall_issue_count", int'(ic0), 3);
`else
        // Two-entry program loops forever; count saturates.
        pulse_clear();
        wr(FN_ORXOR, 4'd9); wr(FN_SHR, 4'd2);
        out_ready = 1'b1;
        pulse_start();
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            if (int'(f0) != ((c % 2 == 0) ? 3 : 6) || !v0 || d0) bad++;
            tick();
        end
        chk("loop_pattern", bad, 0);
        chk("loop_issue_sat", int'(ic0), 255);
        chk("loop_no_done", int'(d0), 0);
        chk("loop_busy", int'(b0), 1);
        pulse_abort();
`endif

        // Fill past capacity, then clear.
        out_ready = 1'b0;
        pulse_clear();
        for (int i = 0; i < 8; i++) wr(3'(i), 4'(15 - i));
        chk("full_len", int'(pl0), 8);
        chk("full_flag", int'(pf0), 1);
        chk("full_no_err", int'(we0), 0);
        wr(FN_CONCAT, 4'd7);
        chk("ninth_wr_err", int'(we0), 1);
        chk("ninth_len", int'(pl0), 8);
        tick();
        chk("wr_err_one_cycle", int'(we0), 0);
        pulse_clear();
        chk("clear_len", int'(pl0), 0);
        chk("clear_full", int'(pf0), 0);

        // Abort on the second handshake; write while running; empty start.
        wr(FN_ADD, 4'd3); wr(FN_MUL, 4'd5); wr(FN_SHL, 4'd1);
        out_ready = 1'b1;
        pulse_start();
        tick();
        pulse_abort();
        chk("abort_issue_count", int'(ic0), 2);
        chk("abort_busy", int'(b0), 0);
        chk("abort_done", int'(d0), 0);
        chk("abort_valid", int'(v0), 0);
        pulse_start();
        wr(FN_RCADD, 4'd1);
        chk("run_wr_err", int'(we0), 1);
        chk("run_wr_len", int'(pl0), 3);
        pulse_abort();
        pulse_clear();
        pulse_start();
        chk("empty_start_busy", int'(b0), 0);
        chk("empty_start_valid", int'(v0), 0);
        chk("empty_start_count", int'(ic0), 2);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 499) != 0);
            wr_en     = ($urandom_range(0, 5) == 0);
            wr_func   = 3'($urandom);
            wr_a      = 4'($urandom);
            clear     = ($urandom_range(0, 39) == 0);
            start     = ($urandom_range(0, 9) == 0);
            abort     = ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        reset_n = 1'b1; wr_en = 1'b0; clear = 1'b0; start = 1'b0; abort = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
